// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        STOP
    } ps2_rx_state_t;

    localparam int unsigned PS2_DATA_BITS       = 8;
    localparam int unsigned PS2_FRAME_BITS      = 11;
    localparam int unsigned PS2_FILTER_LEN_DEF  = 16;
    localparam int unsigned PS2_TIMEOUT_CYC_DEF = 50000;

    // Odd parity over the data byte plus the parity bit.
    function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a persistence filter; idles high.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 16
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic pin_i,
    output logic line_o
);

    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]      sync_q, sync_d;
    logic            line_q, line_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[0], pin_i};
        line_d = line_q;
        cnt_d  = '0;
        // The line only flips after FILTER_LEN consecutive disagreeing samples.
        if (sync_q[1] != line_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                line_d = ~line_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sync_q <= 2'b11;
            line_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            line_q <= line_d;
            cnt_q  <= cnt_d;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: filters the pins, deserializes 11-bit frames,
// and reports one validated scancode byte or an error pulse per frame.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = PS2_FILTER_LEN_DEF,
    parameter int unsigned TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF
) (
    input  logic       CLOCK_50,
    input  logic       clr,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       timeout,
    output logic       busy
);

    localparam int unsigned WdogW = $clog2(TIMEOUT_CYC);
    localparam int unsigned CntW  = $clog2(PS2_FRAME_BITS);

    logic clk_f, dat_f, fall;
    logic clk_prev_q, clk_prev_d;

    ps2_rx_state_t            state_q, state_d;
    logic [CntW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
    logic                     par_q, par_d;
    logic [WdogW-1:0]         wdog_q, wdog_d;
    logic [7:0]               data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     parity_err_q, parity_err_d;
    logic                     frame_err_q, frame_err_d;
    logic                     timeout_q, timeout_d;
    logic                     busy_q, busy_d;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i  (CLOCK_50),
        .clr_i  (clr),
        .pin_i  (PS2_CLK),
        .line_o (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk_i  (CLOCK_50),
        .clr_i  (clr),
        .pin_i  (PS2_DAT),
        .line_o (dat_f)
    );

    assign fall = clk_prev_q & ~clk_f;

    always_comb begin
        clk_prev_d   = clk_f;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        wdog_d       = wdog_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        timeout_d    = 1'b0;

        if (fall) begin
            wdog_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!dat_f) begin
                        state_d   = SHIFT;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                SHIFT: begin
                    shift_d[bit_cnt_q[2:0]] = dat_f;
                    bit_cnt_d               = bit_cnt_q + CntW'(1);
                    if (bit_cnt_q == CntW'(PS2_DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dat_f;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!dat_f) begin
                        frame_err_d = 1'b1;
                    end else if (!ps2_parity_ok(shift_q, par_q)) begin
                        parity_err_d = 1'b1;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // Abort at the edge where the count would reach TIMEOUT_CYC-1, so the
            // pulse lands TIMEOUT_CYC cycles after the last falling edge.
            if (wdog_q == WdogW'(TIMEOUT_CYC - 2)) begin
                state_d   = IDLE;
                wdog_d    = '0;
                timeout_d = 1'b1;
            end else begin
                wdog_d = wdog_q + WdogW'(1);
            end
        end else begin
            wdog_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (clr) begin
            clk_prev_q   <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            wdog_q       <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            clk_prev_q   <= clk_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            wdog_q       <= wdog_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign timeout    = timeout_q;
    assign busy       = busy_q;

endmodule
